// File: rtl/entropy_bit_sampler_if.sv
// Output stream of the entropy sampler: single-bit beats with sequence framing.
// master = sampler (drives the beat), slave = monobit counter (drives ready).
interface entropy_bit_sampler_if;
    logic out_valid;
    logic out_ready;
    logic out_bit;
    logic out_first;
    logic out_last;

    modport master (
        output out_valid,
        output out_bit,
        output out_first,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_bit,
        input  out_first,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/entropy_bit_sampler.sv
// entropy_bit_sampler: synchronises an asynchronous entropy pin, samples it every
// SAMPLE_DIV clocks and frames the samples into SEQ_LEN-bit sequences delivered over
// a valid/ready stream with first/last markers.
// Optional feature: define VON_NEUMANN_EN to pair samples and apply von Neumann
// debiasing (01 -> 0, 10 -> 1, 00/11 discarded) before delivery.
module entropy_bit_sampler #(
    parameter int unsigned SAMPLE_DIV = 16,
    parameter int unsigned SEQ_LEN    = 128
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en_i,
    input  logic                         raw_in_i,
    entropy_bit_sampler_if.master        out_if,
    output logic                         seq_done_o,
    output logic [7:0]                   seq_count_o,
    output logic                         overrun_o
);

    localparam int PW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(SEQ_LEN);

    logic          sync1_q, sync2_q;
    logic [PW-1:0] presc_q, presc_d;
    logic          tick;
    logic          cand_vld, cand_bit;
    logic          valid_q, valid_d;
    logic          bit_q, bit_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          seq_done_q, seq_done_d;
    logic [7:0]    seq_count_q, seq_count_d;
    logic          overrun_q, overrun_d;
    logic          xfer;
`ifdef VON_NEUMANN_EN
    logic          pair_full_q, pair_full_d;
    logic          pair_bit_q, pair_bit_d;
`endif

    // Two-flop synchroniser for the asynchronous entropy pin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= raw_in_i;
            sync2_q <= sync1_q;
        end
    end

    // Prescaler: tick on the last count of each SAMPLE_DIV window; held at 0 while disabled.
    always_comb begin
        tick    = en_i && (presc_q == PW'(SAMPLE_DIV - 1));
        presc_d = presc_q + PW'(1);
        if (!en_i || tick)
            presc_d = '0;
    end

    // Candidate generation: either every tick, or one candidate per unequal sample pair.
    always_comb begin
        cand_vld = 1'b0;
        cand_bit = sync2_q;
`ifdef VON_NEUMANN_EN
        pair_full_d = pair_full_q;
        pair_bit_d  = pair_bit_q;
        if (!en_i) begin
            pair_full_d = 1'b0;
        end else if (tick) begin
            if (!pair_full_q) begin
                pair_full_d = 1'b1;
                pair_bit_d  = sync2_q;
            end else begin
                // The first sample of an unequal pair is the debiased bit.
                pair_full_d = 1'b0;
                cand_vld    = (pair_bit_q != sync2_q);
                cand_bit    = pair_bit_q;
            end
        end
`else
        cand_vld = tick;
`endif
    end

    // Output register, bit counter and sequence bookkeeping next-state.
    always_comb begin
        xfer        = valid_q && out_if.out_ready;
        valid_d     = valid_q;
        bit_d       = bit_q;
        cnt_d       = cnt_q;
        seq_done_d  = 1'b0;
        seq_count_d = seq_count_q;
        overrun_d   = overrun_q;
        if (!en_i) begin
            // Abort: drop the pending beat and restart framing; counters that
            // describe history (seq_count, overrun) are kept.
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            if (xfer) begin
                valid_d = 1'b0;
                if (cnt_q == CW'(SEQ_LEN - 1)) begin
                    cnt_d       = '0;
                    seq_done_d  = 1'b1;
                    seq_count_d = seq_count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            if (cand_vld) begin
                // A beat leaving this cycle frees the single entry for the new candidate.
                if (!valid_q || xfer) begin
                    valid_d = 1'b1;
                    bit_d   = cand_bit;
                end else begin
                    overrun_d = 1'b1;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q     <= '0;
            valid_q     <= 1'b0;
            bit_q       <= 1'b0;
            cnt_q       <= '0;
            seq_done_q  <= 1'b0;
            seq_count_q <= 8'd0;
            overrun_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            valid_q     <= valid_d;
            bit_q       <= bit_d;
            cnt_q       <= cnt_d;
            seq_done_q  <= seq_done_d;
            seq_count_q <= seq_count_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef VON_NEUMANN_EN
    // Pair state for the debiaser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pair_full_q <= 1'b0;
            pair_bit_q  <= 1'b0;
        end else begin
            pair_full_q <= pair_full_d;
            pair_bit_q  <= pair_bit_d;
        end
    end
`endif

    assign out_if.out_valid = valid_q;
    assign out_if.out_bit   = bit_q;
    assign out_if.out_first = valid_q && (cnt_q == '0);
    assign out_if.out_last  = valid_q && (cnt_q == CW'(SEQ_LEN - 1));
    assign seq_done_o       = seq_done_q;
    assign seq_count_o      = seq_count_q;
    assign overrun_o        = overrun_q;

endmodule
